// File: rtl/fas_pkg.sv
// Shared definitions for the single-precision add/sub issuer: op encodings,
// FSM state type, the canonical quiet NaN and the default unit latency.
package fas_pkg;

  localparam logic FAS_OP_ADD = 1'b0;
  localparam logic FAS_OP_SUB = 1'b1;

  localparam logic [31:0] FAS_QNAN = 32'h7FC0_0000;

  localparam int FAS_LATENCY_DEFAULT = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_DRAIN
  } fas_state_e;

endpackage

// File: rtl/fas_issuer_if.sv
// Command, response and unit-side signals of the add/sub issuer.
// master = the issuer itself, slave = dispatch logic plus the add/sub unit.
interface fas_issuer_if #(
  parameter int TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_op;
  logic [31:0]      cmd_a;
  logic [31:0]      cmd_b;
  logic [TAG_W-1:0] cmd_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_q;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  logic             do_fadd;
  logic             do_fsub;
  logic [31:0]      a;
  logic [31:0]      b;
  logic [31:0]      q;
  logic             valid;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready, q, valid,
    output cmd_ready, rsp_valid, rsp_q, rsp_tag, rsp_err, do_fadd, do_fsub, a, b
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready, q, valid,
    input  cmd_ready, rsp_valid, rsp_q, rsp_tag, rsp_err, do_fadd, do_fsub, a, b
  );
endinterface

// File: rtl/fas_issuer.sv
// Single-outstanding issuer for the pipelined fp add/sub unit.
// Optional watchdog enabled by defining FAS_ISSUER_TIMEOUT_EN.
module fas_issuer
  import fas_pkg::*;
#(
  parameter int TAG_W       = 4,
  parameter int FAS_LATENCY = FAS_LATENCY_DEFAULT,
  parameter int TIMEOUT     = 15
) (
  input  logic          clk,
  input  logic          rst,
  fas_issuer_if.master  bus
);

  localparam int DRAIN_W = $clog2(FAS_LATENCY + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(FAS_LATENCY - 1);

  if (FAS_LATENCY < 1 || TIMEOUT < FAS_LATENCY) begin : g_bad_cfg
    $error("fas_issuer: need FAS_LATENCY >= 1 and TIMEOUT >= FAS_LATENCY");
  end

  fas_state_e         state;
  fas_state_e         state_nxt;
  logic               op_r;
  logic [31:0]        a_r;
  logic [31:0]        b_r;
  logic [31:0]        q_r;
  logic [TAG_W-1:0]   tag_r;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               err_r;
  logic               accept;
  logic               got_valid;
  logic               timeout_hit;

`ifdef FAS_ISSUER_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  logic [WAIT_W-1:0] wait_cnt;
`endif

  always_comb begin
    state_nxt     = state;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.do_fadd   = 1'b0;
    bus.do_fsub   = 1'b0;
    accept        = 1'b0;
    got_valid     = 1'b0;
    timeout_hit   = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          accept    = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        bus.do_fadd = (op_r == FAS_OP_ADD);
        bus.do_fsub = (op_r == FAS_OP_SUB);
        state_nxt   = ST_WAIT;
      end
      ST_WAIT: begin
        // A result pulse in the last watchdog cycle still counts as a result.
        if (bus.valid) begin
          got_valid = 1'b1;
          state_nxt = ST_RESP;
        end
`ifdef FAS_ISSUER_TIMEOUT_EN
        else if (wait_cnt == WAIT_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_RESP;
        end
`endif
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = err_r ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_DRAIN;
    endcase
  end

  // Reset lands in DRAIN so a result still in the unit pipeline is flushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_DRAIN;
      drain_cnt <= '0;
      op_r      <= FAS_OP_ADD;
      a_r       <= '0;
      b_r       <= '0;
      q_r       <= '0;
      tag_r     <= '0;
      err_r     <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
      if (accept) begin
        op_r  <= bus.cmd_op;
        a_r   <= bus.cmd_a;
        b_r   <= bus.cmd_b;
        tag_r <= bus.cmd_tag;
      end
      if (got_valid) begin
        q_r   <= bus.q;
        err_r <= 1'b0;
      end else if (timeout_hit) begin
        q_r   <= FAS_QNAN;
        err_r <= 1'b1;
      end
    end
  end

`ifdef FAS_ISSUER_TIMEOUT_EN
  // Counts WAIT cycles; any other state (ISSUE in particular) clears it.
  always_ff @(posedge clk) begin
    if (rst) wait_cnt <= '0;
    else     wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
  end
`endif

  assign bus.a       = a_r;
  assign bus.b       = b_r;
  assign bus.rsp_q   = q_r;
  assign bus.rsp_tag = tag_r;
`ifdef FAS_ISSUER_TIMEOUT_EN
  assign bus.rsp_err = err_r;
`else
  assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_fas_issuer.sv
// Directed bench for fas_issuer with a fixed-latency stub of the add/sub unit.
module tb_fas_issuer;
  import fas_pkg::*;

  localparam int TAG_W = 4;
  localparam int LAT   = 5;
  localparam int TMO   = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fas_issuer_if #(.TAG_W(TAG_W)) bus ();

  fas_issuer #(.TAG_W(TAG_W), .FAS_LATENCY(LAT), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int fails  = 0;

  // Unit stub: results are a hand-computed table, valid LAT cycles after issue.
  bit          stub_en  = 1'b1;
  int          stub_cnt = 0;
  logic [31:0] stub_res;

  function automatic logic [31:0] unit_model(input logic sub, input logic [31:0] x, input logic [31:0] y);
    if (!sub && x == 32'h3F80_0000 && y == 32'h4000_0000) return 32'h4040_0000; // 1+2=3
    if ( sub && x == 32'h4040_0000 && y == 32'h3F80_0000) return 32'h4000_0000; // 3-1=2
    if (!sub && x == 32'h4040_0000 && y == 32'h4040_0000) return 32'h40C0_0000; // 3+3=6
    if ( sub && x == 32'h4000_0000 && y == 32'h4080_0000) return 32'hC000_0000; // 2-4=-2
    return 32'hDEAD_BEEF;
  endfunction

  always @(negedge clk) begin
    bus.valid = 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt = stub_cnt - 1;
      if (stub_cnt == 0 && stub_en) begin
        bus.valid = 1'b1;
        bus.q     = stub_res;
      end
    end
    if (bus.do_fadd || bus.do_fsub) begin
      stub_cnt = LAT;
      stub_res = unit_model(bus.do_fsub, bus.a, bus.b);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic drive_cmd(input logic op, input logic [31:0] x, input logic [31:0] y, input logic [TAG_W-1:0] t);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = x;
    bus.cmd_b     = y;
    bus.cmd_tag   = t;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0;
    bus.cmd_tag = '0; bus.rsp_ready = 1'b1;
    repeat (3) step();
    checks++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.do_fadd, bus.do_fsub, bus.rsp_err} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b required 00000",
                        {bus.cmd_ready, bus.rsp_valid, bus.do_fadd, bus.do_fsub, bus.rsp_err});
    end
    checks++;
    if ({bus.a, bus.b, bus.rsp_q, bus.rsp_tag} !== '0) begin
      fails++; $display("FAIL reset_data: a=%h b=%h q=%h tag=%h required all 0",
                        bus.a, bus.b, bus.rsp_q, bus.rsp_tag);
    end
    rst = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      checks++;
      if (bus.cmd_ready !== 1'b0) begin
        fails++; $display("FAIL reset_drain c%0d: cmd_ready=%b required 0", i, bus.cmd_ready);
      end
      step();
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready: cmd_ready=%b required 1", bus.cmd_ready);
    end
  endtask

  task automatic test_add();
    bit ok;
    wait_idle(ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL add_idle: cmd_ready never 1"); end
    drive_cmd(FAS_OP_ADD, 32'h3F80_0000, 32'h4000_0000, 4'd3);
    step(); bus.cmd_valid = 1'b0;
    checks++;
    if ({bus.do_fadd, bus.do_fsub} !== 2'b10 || bus.a !== 32'h3F80_0000 || bus.b !== 32'h4000_0000) begin
      fails++; $display("FAIL add_issue: fadd=%b fsub=%b a=%h b=%h required 1 0 3f800000 40000000",
                        bus.do_fadd, bus.do_fsub, bus.a, bus.b);
    end
    for (int c = 2; c <= 6; c++) begin
      step();
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.do_fadd !== 1'b0) begin
        fails++; $display("FAIL add_wait c%0d: rsp_valid=%b fadd=%b required 0 0", c, bus.rsp_valid, bus.do_fadd);
      end
    end
    step();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_q !== 32'h4040_0000 || bus.rsp_tag !== 4'd3 || bus.rsp_err !== 1'b0) begin
      fails++; $display("FAIL add_rsp: valid=%b q=%h tag=%0d err=%b required 1 40400000 3 0",
                        bus.rsp_valid, bus.rsp_q, bus.rsp_tag, bus.rsp_err);
    end
    step();
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      fails++; $display("FAIL add_done: rsp_valid=%b cmd_ready=%b required 0 1", bus.rsp_valid, bus.cmd_ready);
    end
  endtask

  task automatic test_sub();
    bit ok;
    int n_fadd = 0;
    wait_idle(ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL sub_idle: cmd_ready never 1"); end
    drive_cmd(FAS_OP_SUB, 32'h4040_0000, 32'h3F80_0000, 4'd9);
    step(); bus.cmd_valid = 1'b0;
    checks++;
    if (bus.do_fsub !== 1'b1) begin
      fails++; $display("FAIL sub_issue: do_fsub=%b required 1", bus.do_fsub);
    end
    for (int c = 1; c <= 7; c++) begin
      if (bus.do_fadd !== 1'b0) n_fadd++;
      if (c < 7) step();
    end
    checks++;
    if (n_fadd != 0) begin fails++; $display("FAIL sub_no_fadd: fadd cycles=%0d required 0", n_fadd); end
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_q !== 32'h4000_0000 || bus.rsp_tag !== 4'd9) begin
      fails++; $display("FAIL sub_rsp: valid=%b q=%h tag=%0d required 1 40000000 9",
                        bus.rsp_valid, bus.rsp_q, bus.rsp_tag);
    end
    step();
  endtask

  task automatic test_backpressure();
    bit ok;
    wait_idle(ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL bp_idle: cmd_ready never 1"); end
    bus.rsp_ready = 1'b0;
    drive_cmd(FAS_OP_SUB, 32'h4000_0000, 32'h4080_0000, 4'd5);
    step();
    // Next command is offered during the whole stall and must not be taken early.
    drive_cmd(FAS_OP_ADD, 32'h4040_0000, 32'h4040_0000, 4'd12);
    repeat (6) step();
    for (int c = 7; c <= 16; c++) begin
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_q !== 32'hC000_0000 || bus.rsp_tag !== 4'd5 ||
          bus.cmd_ready !== 1'b0 || bus.do_fadd !== 1'b0 || bus.do_fsub !== 1'b0) begin
        fails++; $display("FAIL bp_stall c%0d: valid=%b q=%h tag=%0d ready=%b do=%b%b required 1 c0000000 5 0 00",
                          c, bus.rsp_valid, bus.rsp_q, bus.rsp_tag, bus.cmd_ready, bus.do_fadd, bus.do_fsub);
      end
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      fails++; $display("FAIL bp_release: rsp_valid=%b cmd_ready=%b required 0 1", bus.rsp_valid, bus.cmd_ready);
    end
    step(); bus.cmd_valid = 1'b0;
    checks++;
    if (bus.do_fadd !== 1'b1 || bus.a !== 32'h4040_0000) begin
      fails++; $display("FAIL bp_next_issue: fadd=%b a=%h required 1 40400000", bus.do_fadd, bus.a);
    end
    repeat (6) step();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_q !== 32'h40C0_0000 || bus.rsp_tag !== 4'd12) begin
      fails++; $display("FAIL bp_next_rsp: valid=%b q=%h tag=%0d required 1 40c00000 12",
                        bus.rsp_valid, bus.rsp_q, bus.rsp_tag);
    end
    step();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int iss[$];
    int rsp[$];
    logic [TAG_W-1:0] tags[$];
    wait_idle(ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL b2b_idle: cmd_ready never 1"); end
    drive_cmd(FAS_OP_ADD, 32'h3F80_0000, 32'h4000_0000, 4'd7);
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 1) bus.cmd_tag = 4'd8;
      if (c == 9) bus.cmd_valid = 1'b0;
      if (bus.do_fadd === 1'b1) iss.push_back(c);
      if (bus.rsp_valid === 1'b1) begin
        rsp.push_back(c);
        tags.push_back(bus.rsp_tag);
      end
    end
    checks++;
    if (iss.size() != 2 || iss[0] != 1 || iss[1] != 9) begin
      fails++; $display("FAIL b2b_issue: n=%0d first=%0d second=%0d required 2 1 9",
                        iss.size(), iss.size() > 0 ? iss[0] : -1, iss.size() > 1 ? iss[1] : -1);
    end
    checks++;
    if (rsp.size() != 2 || rsp[0] != 7 || rsp[1] != 15 || tags[0] !== 4'd7 || tags[1] !== 4'd8) begin
      fails++; $display("FAIL b2b_rsp: n=%0d cycles=%0d,%0d tags=%0d,%0d required 2 7,15 7,8",
                        rsp.size(), rsp.size() > 0 ? rsp[0] : -1, rsp.size() > 1 ? rsp[1] : -1,
                        tags.size() > 0 ? int'(tags[0]) : -1, tags.size() > 1 ? int'(tags[1]) : -1);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    int n_rsp = 0;
    wait_idle(ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL rmw_idle: cmd_ready never 1"); end
    drive_cmd(FAS_OP_ADD, 32'h3F80_0000, 32'h4000_0000, 4'd4);
    step(); bus.cmd_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus.a !== 32'h0 || bus.rsp_tag !== '0) begin
      fails++; $display("FAIL rmw_clear: a=%h tag=%0d required 0 0", bus.a, bus.rsp_tag);
    end
    for (int c = 4; c <= 8; c++) begin
      checks++;
      if (bus.cmd_ready !== 1'b0) begin
        fails++; $display("FAIL rmw_drain c%0d: cmd_ready=%b required 0", c, bus.cmd_ready);
      end
      if (bus.rsp_valid === 1'b1) n_rsp++;
      step();
    end
    checks++;
    if (bus.cmd_ready !== 1'b1 || n_rsp != 0 || bus.rsp_valid !== 1'b0) begin
      fails++; $display("FAIL rmw_after: cmd_ready=%b responses=%0d rsp_valid=%b required 1 0 0",
                        bus.cmd_ready, n_rsp, bus.rsp_valid);
    end
  endtask

`ifdef FAS_ISSUER_TIMEOUT_EN
  task automatic test_watchdog();
    bit ok;
    int early = 0;
    wait_idle(ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL wd_idle: cmd_ready never 1"); end
    stub_en = 1'b0;
    drive_cmd(FAS_OP_ADD, 32'h3F80_0000, 32'h4000_0000, 4'd6);
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 1) bus.cmd_valid = 1'b0;
      if (bus.rsp_valid !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin fails++; $display("FAIL wd_early: rsp_valid cycles=%0d required 0", early); end
    step();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_q !== FAS_QNAN || bus.rsp_tag !== 4'd6) begin
      fails++; $display("FAIL wd_rsp: valid=%b err=%b q=%h tag=%0d required 1 1 7fc00000 6",
                        bus.rsp_valid, bus.rsp_err, bus.rsp_q, bus.rsp_tag);
    end
    stub_en = 1'b1;
    for (int c = 18; c <= 22; c++) begin
      step();
      checks++;
      if (bus.cmd_ready !== 1'b0) begin
        fails++; $display("FAIL wd_drain c%0d: cmd_ready=%b required 0", c, bus.cmd_ready);
      end
    end
    step();
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      fails++; $display("FAIL wd_ready: cmd_ready=%b required 1", bus.cmd_ready);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_wait();
    test_add();
`ifdef FAS_ISSUER_TIMEOUT_EN
    test_watchdog();
    test_add();
`endif
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
